// File: rtl/ecc_58_pkg.sv
// Shared types for the 58-bit ECC error logger.
// Holds the 2-bit error-type codes, the capture FSM encoding and a priority helper.
package ecc_58_pkg;

    // The codes are visible on first_type, so their values are fixed.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SBIT  = 2'b01,
        ERR_DBIT  = 2'b10,
        ERR_FAULT = 2'b11
    } err_type_e;

    // The capture FSM either waits for a first error or holds one.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } cap_state_e;

    // Collapse the detector flags into one type code.
    // Priority: fault, then dbit, then sbit.
    function automatic err_type_e err_prio(
        input logic sbit,
        input logic dbit,
        input logic fault
    );
        err_type_e t;
        t = ERR_NONE;
        if (fault) begin
            t = ERR_FAULT;
        end else if (dbit) begin
            t = ERR_DBIT;
        end else if (sbit) begin
            t = ERR_SBIT;
        end
        return t;
    endfunction

endpackage

// File: rtl/ecc_58_sat_cnt.sv
// Saturating event counter with synchronous clear and a threshold-crossing pulse.
// Ports: clk, rst_n, inc, clr, thresh -> cnt (registered), hit (combinational).
module ecc_58_sat_cnt
    import ecc_58_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] thresh,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 hit
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 adv;

    // Clear wins, but an event on the clearing cycle still counts once.
    // adv marks that this edge moves the count onto a new value.
    always_comb begin
        cnt_d = cnt_q;
        adv   = 1'b0;
        if (clr) begin
            cnt_d = inc ? ONE : '0;
            adv   = inc;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
            adv   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires only when the count advances onto the threshold.
    // A saturated counter no longer advances, so it cannot re-fire.
    assign hit = adv && (thresh != '0) && (cnt_d == thresh);
    assign cnt = cnt_q;

endmodule

// File: rtl/ecc_58_err_log.sv
// Error logger and interrupt stage after the 58-bit ECC detector on the FIFO read path.
// Ports: rd_vld/rd_addr/sbit_err/dbit_err/ecc_fault in, log_clr/irq_ack controls,
// sbit_cnt/dbit_cnt/fault_cnt, first_vld/first_type/first_addr, err_irq out.
// Optional macro ECC_58_ERR_LOG_SBIT_THRESH_EN adds sbit_thresh as an irq source.
module ecc_58_err_log
    import ecc_58_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  log_clr,
    input  logic                  irq_ack,
`ifdef ECC_58_ERR_LOG_SBIT_THRESH_EN
    input  logic [CNT_WIDTH-1:0]  sbit_thresh,
`endif
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic                  first_vld,
    output logic [1:0]            first_type,
    output logic [ADDR_WIDTH-1:0] first_addr,
    output logic                  err_irq
);

    logic                  sb_ev;
    logic                  db_ev;
    logic                  ft_ev;
    logic                  any_ev;
    err_type_e             ev_type;
    logic [CNT_WIDTH-1:0]  sb_thr;
    logic [2:0]            hit_w;
    logic                  irq_set;

    cap_state_e            state_q;
    cap_state_e            state_d;
    logic                  first_vld_q;
    logic                  first_vld_d;
    err_type_e             first_type_q;
    err_type_e             first_type_d;
    logic [ADDR_WIDTH-1:0] first_addr_q;
    logic [ADDR_WIDTH-1:0] first_addr_d;
    logic                  irq_q;
    logic                  irq_d;

    // Flags only count while the read is valid.
    assign sb_ev   = rd_vld & sbit_err;
    assign db_ev   = rd_vld & dbit_err;
    assign ft_ev   = rd_vld & ecc_fault;
    assign any_ev  = sb_ev | db_ev | ft_ev;
    assign ev_type = err_prio(sb_ev, db_ev, ft_ev);

`ifdef ECC_58_ERR_LOG_SBIT_THRESH_EN
    assign sb_thr = sbit_thresh;
`else
    assign sb_thr = '0;
`endif

    // Only the sbit counter has a threshold; the others are tied to zero,
    // so their hit outputs stay low and drop out of the irq set term.
    ecc_58_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sbit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (sb_ev),
        .clr    (log_clr),
        .thresh (sb_thr),
        .cnt    (sbit_cnt),
        .hit    (hit_w[0])
    );

    ecc_58_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dbit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (db_ev),
        .clr    (log_clr),
        .thresh ('0),
        .cnt    (dbit_cnt),
        .hit    (hit_w[1])
    );

    ecc_58_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fault_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ft_ev),
        .clr    (log_clr),
        .thresh ('0),
        .cnt    (fault_cnt),
        .hit    (hit_w[2])
    );

    // Capture FSM. A clear frees the capture first, so an event on the
    // same cycle is captured as the new first error.
    always_comb begin
        state_d      = state_q;
        first_vld_d  = first_vld_q;
        first_type_d = first_type_q;
        first_addr_d = first_addr_q;
        if (log_clr) begin
            state_d      = ST_IDLE;
            first_vld_d  = 1'b0;
            first_type_d = ERR_NONE;
            first_addr_d = '0;
        end
        if (any_ev && (log_clr || (state_q == ST_IDLE))) begin
            state_d      = ST_HELD;
            first_vld_d  = 1'b1;
            first_type_d = ev_type;
            first_addr_d = rd_addr;
        end
    end

    // A new irq source on the ack/clear cycle keeps the line high.
    assign irq_set = db_ev | ft_ev | (|hit_w);

    always_comb begin
        irq_d = irq_q;
        if (log_clr || irq_ack) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            first_vld_q  <= 1'b0;
            first_type_q <= ERR_NONE;
            first_addr_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_vld_q  <= first_vld_d;
            first_type_q <= first_type_d;
            first_addr_q <= first_addr_d;
            irq_q        <= irq_d;
        end
    end

    assign first_vld  = first_vld_q;
    assign first_type = first_type_q;
    assign first_addr = first_addr_q;
    assign err_irq    = irq_q;

endmodule

// File: doc/ecc_58_err_log.md
# ecc_58_err_log

Error logging and interrupt stage directly downstream of the 58-bit ECC fault detector on the FIFO read path. It samples the detector's per-read `sbit_err`, `dbit_err` and `ecc_fault` flags whenever a read is valid. It keeps saturating event counters, latches the type and address of the first error since the last clear, and raises a level interrupt that software acknowledges. All outputs are registered; the block never alters read data.

## Interface

Parameters:
- `ADDR_WIDTH`, default 6: width of the FIFO read address being logged.
- `CNT_WIDTH`, default 16: width of each saturating counter.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rd_vld`, input, 1: detector outputs and `rd_addr` are valid this cycle.
- `rd_addr`, input, ADDR_WIDTH: FIFO address of the current read.
- `sbit_err`, input, 1: single-bit corrected error from the detector.
- `dbit_err`, input, 1: double-bit uncorrectable error from the detector.
- `ecc_fault`, input, 1: detector self-check mismatch.
- `log_clr`, input, 1: single-cycle pulse that clears counters, capture and interrupt.
- `irq_ack`, input, 1: single-cycle pulse that deasserts `err_irq`.
- `sbit_cnt`, output, CNT_WIDTH: count of single-bit events.
- `dbit_cnt`, output, CNT_WIDTH: count of double-bit events.
- `fault_cnt`, output, CNT_WIDTH: count of detector-fault events.
- `first_vld`, output, 1: a first-error capture is held.
- `first_type`, output, 2: type of the captured error (01 sbit, 10 dbit, 11 fault).
- `first_addr`, output, ADDR_WIDTH: address of the captured error.
- `err_irq`, output, 1: level interrupt.

## Operation

- An event is qualified only when `rd_vld` is high; flags with `rd_vld` low are ignored.
- Each flag increments its own counter independently. Counters saturate at all-ones and never wrap.
- Event type priority for capture and interrupt: `ecc_fault` > `dbit_err` > `sbit_err`. If `sbit_err` and `dbit_err` are both set, both counters increment and the capture type is 10.
- Capture FSM:
  - IDLE: on a qualified event, load `first_type` and `first_addr`, set `first_vld`, and go to HELD.
  - HELD: ignore further events for capture (counters still run). `log_clr` returns the FSM to IDLE.
- `err_irq` is set on any qualified dbit or fault event, in either state. It is cleared by `irq_ack` or `log_clr`. sbit events alone do not interrupt (see Configuration).
- `log_clr` zeroes all counters, `first_*` and `err_irq`.
- `log_clr` coincident with a qualified event: the clear applies first, then the event is recorded. The result is count = 1 for that type, capture loaded, FSM in HELD, and `err_irq` set if the event is dbit or fault.
- `irq_ack` coincident with a new irq-causing event: `err_irq` remains 1 (set wins).
- `log_clr` and `irq_ack` together: same as `log_clr` alone.

## Timing

- Reset: all outputs 0 and FSM in IDLE, applied immediately on `rst_n` low.
- All outputs update on the clock edge that samples the event, so they are visible the cycle after `rd_vld`.
- `log_clr` and `irq_ack` take effect on the next edge.
- Back-to-back qualified events every cycle are supported with no loss.
- A reset asserted mid-stream discards everything; the first qualified read after reset release is recorded normally.

## Configuration

- Macro `ECC_58_ERR_LOG_SBIT_THRESH_EN`.
- Defined:
  - Adds input `sbit_thresh` [CNT_WIDTH].
  - `err_irq` is also set on the edge where `sbit_cnt` transitions to a value equal to `sbit_thresh`, for nonzero thresholds only. It fires once per crossing; after saturation it does not re-fire.
  - A threshold of 0 disables this interrupt source.
- Undefined: the port is absent and sbit events never raise `err_irq`.

## Structure

- Shared package `ecc_58_pkg` holds the 2-bit error-type constants (`ERR_NONE`, `ERR_SBIT`, `ERR_DBIT`, `ERR_FAULT`) and the FSM state encoding.
- One sub-module, `ecc_58_sat_cnt`:
  - Parameterised by CNT_WIDTH, with inputs `inc` and `clr`.
  - Clear has priority over increment, so clear-plus-increment yields 1.
  - Exposes a `hit` pulse used for the threshold crossing.
  - Instantiated three times.

## Test plan

- Reset, then 3 sbit reads at addr 5, 6, 7 → `sbit_cnt` = 3, `first_addr` = 5, `first_type` = 01, `err_irq` = 0.
- dbit at addr 9 with `rd_vld` = 1, then `irq_ack` → `err_irq` = 1 for exactly the cycles until the ack edge, then 0; `dbit_cnt` = 1.
- `ecc_fault` and `dbit_err` together at addr 12 → `first_type` = 11, `fault_cnt` = 1, `dbit_cnt` = 1, `err_irq` = 1.
- `log_clr` coincident with an sbit at addr 3 → `sbit_cnt` = 1, `first_addr` = 3, other counters 0.
- CNT_WIDTH = 4 with 20 consecutive sbit reads → `sbit_cnt` holds at 15. With the macro defined and `sbit_thresh` = 10, `err_irq` rises on the 10th event only.
- `rd_vld` = 0 with all flags high for 8 cycles → no counter, capture or irq change.
